// File: rtl/sd_multi_sector_reader.sv
// ---------------------------------------------------------------------------
// sd_multi_sector_reader
//
// Sequencer between an sd_controller and user logic. On a start request it
// reads NUM_SECTORS consecutive sectors beginning at base_addr, streams every
// received byte out with its byte/sector index, keeps a running 16-bit
// checksum of the run, aborts to an error state when the controller stalls
// for TIMEOUT_CYC cycles, and mirrors progress on five board LEDs.
//
// Parameters
//   SECTOR_BYTES  bytes per sector; byte_idx wraps at this value
//   NUM_SECTORS   sectors per run (>= 1)
//   BLOCK_ADDR    1: address step 1 (block addressing), 0: step SECTOR_BYTES
//   TIMEOUT_CYC   idle cycles tolerated while waiting for ready or a byte
//
// Ports
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   start            in   one-cycle run request (accepted in IDLE/DONE/ERR)
//   base_addr        in   first sector address, latched on an accepted start
//   ctrl_ready       in   controller ready
//   ctrl_byte_avail  in   controller byte-available level
//   ctrl_dout        in   controller data byte
//   ctrl_rd          out  one-cycle read request to the controller
//   ctrl_address     out  sector address for the current read
//   byte_out         out  received byte
//   byte_valid       out  one-cycle strobe qualifying byte_out
//   byte_idx         out  byte position within the current sector
//   sector_idx       out  sector position within the run
//   checksum         out  sum of all accepted bytes of the run, mod 2^16
//   busy             out  run in progress
//   done             out  run finished successfully (held until next start)
//   error            out  run aborted by timeout (held until next start)
//   led              out  {error, done, busy, sector_idx[1:0]}
// ---------------------------------------------------------------------------
module sd_multi_sector_reader #(
  parameter int SECTOR_BYTES = 512,
  parameter int NUM_SECTORS  = 4,
  parameter int BLOCK_ADDR   = 1,
  parameter int TIMEOUT_CYC  = 2500000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [31:0]                        base_addr,
  input  logic                               ctrl_ready,
  input  logic                               ctrl_byte_avail,
  input  logic [7:0]                         ctrl_dout,
  output logic                               ctrl_rd,
  output logic [31:0]                        ctrl_address,
  output logic [7:0]                         byte_out,
  output logic                               byte_valid,
  output logic [$clog2(SECTOR_BYTES)-1:0]    byte_idx,
  output logic [$clog2(NUM_SECTORS+1)-1:0]   sector_idx,
  output logic [15:0]                        checksum,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [4:0]                         led
);

  localparam int BW = $clog2(SECTOR_BYTES);
  localparam int SW = $clog2(NUM_SECTORS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BW-1:0] LAST_BYTE   = BW'(SECTOR_BYTES - 1);
  localparam logic [BW-1:0] BYTE_ONE    = BW'(1);
  localparam logic [SW-1:0] LAST_SECTOR = SW'(NUM_SECTORS - 1);
  localparam logic [SW-1:0] SECTOR_ONE  = SW'(1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE     = TW'(1);
  localparam logic [31:0]   ADDR_STEP   = (BLOCK_ADDR != 0) ? 32'd1 : 32'(SECTOR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ISSUE    = 3'd2,
    S_RECV     = 3'd3,
    S_NEXT     = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            avail_q_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic            accept_s;
  logic            last_byte_s;
  logic            start_ok_s;
  logic            tmo_count_s;
  logic            tmo_hit_s;
  logic            busy_nxt_s;
  logic            done_nxt_s;
  logic            error_nxt_s;
  logic            rd_nxt_s;
  logic [1:0]      sector_led_s;

  // A byte is taken only on a rising edge of byte_avail and only while receiving.
  assign accept_s    = (state_r == S_RECV) && ctrl_byte_avail && !avail_q_r;
  assign last_byte_s = accept_s && (byte_idx == LAST_BYTE);
  assign start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
  // An edge in the timeout cycle counts as progress, so it cancels the timeout.
  assign tmo_count_s = ((state_r == S_WAIT_RDY) && !ctrl_ready) ||
                       ((state_r == S_RECV) && !accept_s);
  assign tmo_hit_s   = tmo_count_s && (tmo_cnt_r == TMO_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt_s = S_WAIT_RDY;
        else       state_nxt_s = state_r;
      end
      S_WAIT_RDY: begin
        if (ctrl_ready)     state_nxt_s = S_ISSUE;
        else if (tmo_hit_s) state_nxt_s = S_ERR;
        else                state_nxt_s = S_WAIT_RDY;
      end
      S_ISSUE: state_nxt_s = S_RECV;
      S_RECV: begin
        if (last_byte_s)    state_nxt_s = S_NEXT;
        else if (tmo_hit_s) state_nxt_s = S_ERR;
        else                state_nxt_s = S_RECV;
      end
      S_NEXT: begin
        if (sector_idx == LAST_SECTOR) state_nxt_s = S_DONE;
        else                           state_nxt_s = S_WAIT_RDY;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the flags can be registered.
  always_comb begin
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    error_nxt_s = 1'b0;
    rd_nxt_s    = 1'b0;
    case (state_nxt_s)
      S_WAIT_RDY: busy_nxt_s = 1'b1;
      S_ISSUE: begin
        busy_nxt_s = 1'b1;
        rd_nxt_s   = 1'b1;
      end
      S_RECV:  busy_nxt_s  = 1'b1;
      S_NEXT:  busy_nxt_s  = 1'b1;
      S_DONE:  done_nxt_s  = 1'b1;
      S_ERR:   error_nxt_s = 1'b1;
      default: busy_nxt_s  = 1'b0;
    endcase
  end

  // Registered status flags and controller read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      ctrl_rd <= 1'b0;
    end else begin
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
      error   <= error_nxt_s;
      ctrl_rd <= rd_nxt_s;
    end
  end

  // Byte-available edge detector and the outgoing byte stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q_r  <= 1'b0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      avail_q_r  <= ctrl_byte_avail;
      byte_valid <= accept_s;
      if (accept_s) begin
        byte_out <= ctrl_dout;
      end
    end
  end

  // Run bookkeeping: byte/sector indices, checksum and sector address.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= '0;
      sector_idx   <= '0;
      checksum     <= 16'd0;
      ctrl_address <= 32'd0;
    end else if (start_ok_s) begin
      byte_idx     <= '0;
      sector_idx   <= '0;
      checksum     <= 16'd0;
      ctrl_address <= base_addr;
    end else begin
      if (accept_s) begin
        checksum <= checksum + {8'd0, ctrl_dout};
        if (last_byte_s) byte_idx <= '0;
        else             byte_idx <= byte_idx + BYTE_ONE;
      end
      // Address only moves in NEXT, so it is stable from WAIT_RDY through RECV.
      if (state_r == S_NEXT) begin
        sector_idx   <= sector_idx + SECTOR_ONE;
        ctrl_address <= ctrl_address + ADDR_STEP;
      end
    end
  end

  // Idle-cycle counter; any cycle that is not a stall (or the hit itself) clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if (tmo_count_s && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Low LED pair shows the sector index, zero-extended when the index is 1 bit wide.
  always_comb begin
    sector_led_s = 2'(sector_idx);
  end

  assign led = {error, done, busy, sector_led_s};

endmodule

// File: tb/tb_sd_multi_sector_reader.sv
`timescale 1ns/1ps
// Directed bench for sd_multi_sector_reader: two instances (block and byte
// addressing) share all inputs; the bench plays the sd_controller role.
module tb_sd_multi_sector_reader;

  localparam int SB  = 512;
  localparam int NS  = 2;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        ctrl_ready;
  logic        ctrl_byte_avail;
  logic [7:0]  ctrl_dout;

  logic        rd1, bval1, busy1, done1, err1;
  logic [31:0] addr1;
  logic [7:0]  bout1;
  logic [8:0]  bidx1;
  logic [1:0]  sidx1;
  logic [15:0] csum1;
  logic [4:0]  led1;

  logic        rd2, bval2, busy2, done2, err2;
  logic [31:0] addr2;
  logic [7:0]  bout2;
  logic [8:0]  bidx2;
  logic [1:0]  sidx2;
  logic [15:0] csum2;
  logic [4:0]  led2;

  sd_multi_sector_reader #(.SECTOR_BYTES(SB), .NUM_SECTORS(NS), .BLOCK_ADDR(1), .TIMEOUT_CYC(TMO)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .ctrl_ready(ctrl_ready), .ctrl_byte_avail(ctrl_byte_avail), .ctrl_dout(ctrl_dout),
    .ctrl_rd(rd1), .ctrl_address(addr1), .byte_out(bout1), .byte_valid(bval1),
    .byte_idx(bidx1), .sector_idx(sidx1), .checksum(csum1),
    .busy(busy1), .done(done1), .error(err1), .led(led1));

  sd_multi_sector_reader #(.SECTOR_BYTES(SB), .NUM_SECTORS(NS), .BLOCK_ADDR(0), .TIMEOUT_CYC(TMO)) dut2 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .ctrl_ready(ctrl_ready), .ctrl_byte_avail(ctrl_byte_avail), .ctrl_dout(ctrl_dout),
    .ctrl_rd(rd2), .ctrl_address(addr2), .byte_out(bout2), .byte_valid(bval2),
    .byte_idx(bidx2), .sector_idx(sidx2), .checksum(csum2),
    .busy(busy2), .done(done2), .error(err2), .led(led2));

  always #20 clk = ~clk;

  // Observed stream and read requests, sampled on the falling edge.
  int          obs_valid = 0;
  logic [15:0] obs_sum = 16'd0;
  int          rd_cnt = 0;
  int          rd2_cnt = 0;
  logic [31:0] rd_addr  [0:63];
  logic [31:0] rd2_addr [0:63];

  always @(negedge clk) begin
    if (bval1 === 1'b1) begin
      obs_valid <= obs_valid + 1;
      obs_sum   <= obs_sum + {8'd0, bout1};
    end
    if (rd1 === 1'b1) begin
      rd_addr[rd_cnt[5:0]] <= addr1;
      rd_cnt <= rd_cnt + 1;
    end
    if (rd2 === 1'b1) begin
      rd2_addr[rd2_cnt[5:0]] <= addr2;
      rd2_cnt <= rd2_cnt + 1;
    end
  end

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_sum;
  int          exp_valid;
  int          v_base, r_base, r2_base;
  logic [15:0] s_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    ctrl_dout = d;
    ctrl_byte_avail = 1'b1;
    cyc();
    ctrl_byte_avail = 1'b0;
    cyc();
    exp_sum = exp_sum + {8'd0, d};
    exp_valid++;
  endtask

  // Bytes carry (n & 0xFF) where n counts from 'first'.
  task automatic sector(input int nbytes, input int first);
    for (int n = 0; n < nbytes; n++) send_byte(8'(first + n));
  endtask

  task automatic wait_rd(input string tag);
    int k = 0;
    while (rd1 !== 1'b1 && k < 50) begin
      cyc();
      k++;
    end
    check({tag, "_rd_seen"}, {31'd0, rd1}, 32'd1);
    cyc();
  endtask

  task automatic begin_run(input logic [31:0] base, input string tag);
    v_base = obs_valid; s_base = obs_sum; r_base = rd_cnt; r2_base = rd2_cnt;
    exp_sum = 16'd0; exp_valid = 0;
    base_addr = base;
    start = 1'b1;
    cyc();
    start = 1'b0;
    base_addr = 32'hFFFF_FFFF;
    check({tag, "_start_busy"}, {31'd0, busy1}, 32'd1);
    check({tag, "_start_done"}, {31'd0, done1}, 32'd0);
    check({tag, "_start_err"},  {31'd0, err1},  32'd0);
    check({tag, "_start_csum"}, {16'd0, csum1}, 32'd0);
    check({tag, "_start_idx"},  {21'd0, sidx1, bidx1}, 32'd0);
    check({tag, "_start_addr"}, addr1, base);
  endtask

  task automatic end_run(input logic [31:0] base, input string tag);
    int k = 0;
    logic [15:0] d16;
    while (done1 !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    check({tag, "_done"}, {31'd0, done1}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_err"},  {31'd0, err1},  32'd0);
    check({tag, "_led"},  {27'd0, led1},  32'b01010);
    check({tag, "_sidx"}, {30'd0, sidx1}, 32'd2);
    check({tag, "_bidx"}, {23'd0, bidx1}, 32'd0);
    check({tag, "_csum"}, {16'd0, csum1}, {16'd0, exp_sum});
    check({tag, "_nvalid"}, obs_valid - v_base, exp_valid);
    d16 = obs_sum - s_base;
    check({tag, "_stream_sum"}, {16'd0, d16}, {16'd0, exp_sum});
    check({tag, "_nrd"},   rd_cnt - r_base, 32'd2);
    check({tag, "_addr0"}, rd_addr[r_base % 64], base);
    check({tag, "_addr1"}, rd_addr[(r_base + 1) % 64], base + 32'd1);
  endtask

  initial begin
    int n;
    int vb;
    reset = 1'b1; start = 1'b0; base_addr = 32'd0;
    ctrl_ready = 1'b0; ctrl_byte_avail = 1'b0; ctrl_dout = 8'd0;
    exp_sum = 16'd0; exp_valid = 0;
    repeat (3) cyc();

    // Reset state
    check("rst_rd",   {31'd0, rd1},   32'd0);
    check("rst_addr", addr1,          32'd0);
    check("rst_bout", {24'd0, bout1}, 32'd0);
    check("rst_bval", {31'd0, bval1}, 32'd0);
    check("rst_idx",  {21'd0, sidx1, bidx1}, 32'd0);
    check("rst_csum", {16'd0, csum1}, 32'd0);
    check("rst_flags", {29'd0, busy1, done1, err1}, 32'd0);
    check("rst_led",  {27'd0, led1},  32'd0);
    check("rst2_all", {rd2, bval2, busy2, done2, err2, bout2, led2, csum2[8:0]}, 32'd0);
    check("rst2_misc", {addr2[15:0], csum2[15:9], bidx2}, {sidx2, 30'd0});
    reset = 1'b0;
    cyc();
    check("idle_busy", {31'd0, busy1}, 32'd0);

    // 1: block addressing, base 0x100; each 512-byte sector of (n & 0xFF)
    //    sums to 0xFF00, so the two-sector run totals 0xFE00 mod 2^16.
    ctrl_ready = 1'b1;
    begin_run(32'h100, "t1");
    for (int s = 0; s < NS; s++) begin
      wait_rd("t1");
      sector(SB, s * SB);
    end
    end_run(32'h100, "t1");
    check("t1_csum_const", {16'd0, csum1}, 32'h0000_FE00);
    check("t1_nvalid_const", obs_valid - v_base, 32'd1024);

    // 2: byte addressing instance steps by 512
    begin_run(32'h200, "t2");
    for (int s = 0; s < NS; s++) begin
      wait_rd("t2");
      sector(SB, s * SB);
    end
    end_run(32'h200, "t2");
    check("t2_b_done",  {31'd0, done2}, 32'd1);
    check("t2_b_nrd",   rd2_cnt - r2_base, 32'd2);
    check("t2_b_addr0", rd2_addr[r2_base % 64], 32'h200);
    check("t2_b_addr1", rd2_addr[(r2_base + 1) % 64], 32'h400);

    // 3: ready never comes -> error exactly TMO cycles after entering WAIT_RDY
    ctrl_ready = 1'b0;
    begin_run(32'h300, "t3");
    repeat (TMO - 1) cyc();
    check("t3_err_before", {31'd0, err1},  32'd0);
    check("t3_busy_before", {31'd0, busy1}, 32'd1);
    cyc();
    check("t3_err_at", {31'd0, err1}, 32'd1);
    check("t3_led",    {27'd0, led1}, 32'b10000);
    check("t3_no_rd",  rd_cnt - r_base, 32'd0);

    // 4: stall after byte 37 of sector 1
    ctrl_ready = 1'b1;
    begin_run(32'h400, "t4");
    wait_rd("t4");
    sector(SB, 0);
    wait_rd("t4b");
    sector(38, SB);
    n = 0;
    while (err1 !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    check("t4_tmo_cycles", n, 32'd99);
    check("t4_err",  {31'd0, err1},  32'd1);
    check("t4_sidx", {30'd0, sidx1}, 32'd1);
    check("t4_bidx", {23'd0, bidx1}, 32'd38);
    check("t4_flags", {29'd0, busy1, done1, rd1}, 32'd0);
    check("t4_led",  {27'd0, led1},  32'b10001);
    check("t4_csum", {16'd0, csum1}, {16'd0, exp_sum});
    // a byte arriving in ERR is ignored
    vb = obs_valid;
    ctrl_dout = 8'hAA; ctrl_byte_avail = 1'b1;
    cyc();
    ctrl_byte_avail = 1'b0;
    cyc();
    check("t4_err_byte_ignored", obs_valid - vb, 32'd0);
    check("t4_err_csum_kept", {16'd0, csum1}, {16'd0, exp_sum});
    begin_run(32'h500, "t4r");
    for (int s = 0; s < NS; s++) begin
      wait_rd("t4r");
      sector(SB, s * SB);
    end
    end_run(32'h500, "t4r");

    // 5: reset in the middle of RECV
    begin_run(32'h600, "t5");
    wait_rd("t5");
    sector(10, 0);
    check("t5_bidx_mid", {23'd0, bidx1}, 32'd10);
    reset = 1'b1;
    cyc();
    check("t5_rd",   {31'd0, rd1},   32'd0);
    check("t5_addr", addr1,          32'd0);
    check("t5_bout", {24'd0, bout1}, 32'd0);
    check("t5_bval", {31'd0, bval1}, 32'd0);
    check("t5_idx",  {21'd0, sidx1, bidx1}, 32'd0);
    check("t5_csum", {16'd0, csum1}, 32'd0);
    check("t5_flags", {29'd0, busy1, done1, err1}, 32'd0);
    check("t5_led",  {27'd0, led1},  32'd0);
    reset = 1'b0;
    cyc();

    // 6: run after reset; start while busy and byte_avail held high 5 cycles
    begin_run(32'h700, "t6");
    wait_rd("t6");
    vb = obs_valid;
    ctrl_dout = 8'h5A; ctrl_byte_avail = 1'b1;
    cyc();
    base_addr = 32'hDEAD_0000; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    ctrl_byte_avail = 1'b0;
    cyc();
    exp_sum = exp_sum + 16'h005A;
    exp_valid++;
    check("t6_one_byte", obs_valid - vb, 32'd1);
    check("t6_bidx",  {23'd0, bidx1}, 32'd1);
    check("t6_bout",  {24'd0, bout1}, 32'h5A);
    check("t6_csum",  {16'd0, csum1}, 32'h5A);
    check("t6_addr",  addr1, 32'h700);
    check("t6_busy",  {31'd0, busy1}, 32'd1);
    sector(SB - 1, 1);
    wait_rd("t6b");
    sector(SB, SB);
    end_run(32'h700, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
